// File: rtl/compare_sched.sv
// Round-robin scheduler sharing one compare unit between two requesters.
// Optional build macro COMPARE_SCHED_SIGNED_EN adds per-request signed comparison.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ALU_SMALLER
`define ALU_SMALLER  0
`define ALU_EQUAL    1
`define ALU_LARGER   2
`define ALU_NSMALLER 3
`define ALU_NEQUAL   4
`define ALU_NLARGER  5
`endif

module compare_sched #(
   parameter int unsigned RR_INIT   = 0,
   parameter int unsigned IDLE_ZERO = 1
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef COMPARE_SCHED_SIGNED_EN
   input  logic                   req0_signed,
   input  logic                   req1_signed,
`endif
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [`DATA_WIDTH-1:0] req0_op0,
   input  logic [`DATA_WIDTH-1:0] req0_op1,
   input  logic [`DATA_WIDTH-1:0] req0_relation,
   output logic                   resp0_valid,
   input  logic                   resp0_ready,
   output logic [`DATA_WIDTH-1:0] resp0_result,
   output logic                   resp0_err,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [`DATA_WIDTH-1:0] req1_op0,
   input  logic [`DATA_WIDTH-1:0] req1_op1,
   input  logic [`DATA_WIDTH-1:0] req1_relation,
   output logic                   resp1_valid,
   input  logic                   resp1_ready,
   output logic [`DATA_WIDTH-1:0] resp1_result,
   output logic                   resp1_err,
   output logic [`DATA_WIDTH-1:0] cmp_op0,
   output logic [`DATA_WIDTH-1:0] cmp_op1,
   output logic [`DATA_WIDTH-1:0] cmp_relation,
   input  logic [`DATA_WIDTH-1:0] cmp_result
);

   localparam int unsigned DW         = `DATA_WIDTH;
   localparam logic        LP_RR_INIT = 1'(RR_INIT);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_prio;
   logic          r_owner;
   logic [DW-1:0] r_op0;
   logic [DW-1:0] r_op1;
   logic [DW-1:0] r_rel;
   logic [DW-1:0] r_res0;
   logic [DW-1:0] r_res1;
   logic          r_err0;
   logic          r_err1;
`ifdef COMPARE_SCHED_SIGNED_EN
   logic          r_sgn;
`endif

   logic          w_grant0;
   logic          w_grant1;
   logic          w_accept;
   logic          w_rel_ok;
   logic          w_bit;
   logic          w_flip;
   logic          w_drive;
   logic [DW-1:0] w_msb_mask;
   logic          w_unused_cmp;

   // Requester 1 wins when alone or when it holds priority.
   assign w_grant1 = req1_valid & (~req0_valid | r_prio);
   assign w_grant0 = req0_valid & ~w_grant1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            req0_ready = w_grant0;
            req1_ready = w_grant1;
            if (w_grant0 | w_grant1) begin
               w_accept = 1'b1;
               w_next   = S_EXEC;
            end
         end
         S_EXEC: w_next = S_RESP;
         S_RESP: begin
            resp0_valid = ~r_owner;
            resp1_valid = r_owner;
            if (r_owner ? resp1_ready : resp0_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Relation decode guards against codes the compare unit does not define.
   always_comb begin
      w_rel_ok = 1'b0;
      case (r_rel)
         DW'(`ALU_SMALLER), DW'(`ALU_EQUAL),   DW'(`ALU_LARGER),
         DW'(`ALU_NSMALLER), DW'(`ALU_NEQUAL), DW'(`ALU_NLARGER): w_rel_ok = 1'b1;
         default: w_rel_ok = 1'b0;
      endcase
   end

   assign w_bit        = w_rel_ok & cmp_result[0];
   assign w_unused_cmp = ^cmp_result[DW-1:1];

`ifdef COMPARE_SCHED_SIGNED_EN
   assign w_flip = r_sgn;
`else
   assign w_flip = 1'b0;
`endif

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign w_msb_mask   = {w_flip, {(DW-1){1'b0}}};
   assign w_drive      = (r_state == S_EXEC) || (IDLE_ZERO == 0);
   assign cmp_op0      = w_drive ? (r_op0 ^ w_msb_mask) : '0;
   assign cmp_op1      = w_drive ? (r_op1 ^ w_msb_mask) : '0;
   assign cmp_relation = w_drive ? r_rel : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio  <= LP_RR_INIT;
         r_owner <= 1'b0;
         r_op0   <= '0;
         r_op1   <= '0;
         r_rel   <= '0;
         r_res0  <= '0;
         r_res1  <= '0;
         r_err0  <= 1'b0;
         r_err1  <= 1'b0;
`ifdef COMPARE_SCHED_SIGNED_EN
         r_sgn   <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_owner <= w_grant1;
            r_prio  <= ~w_grant1;
            r_op0   <= w_grant1 ? req1_op0 : req0_op0;
            r_op1   <= w_grant1 ? req1_op1 : req0_op1;
            r_rel   <= w_grant1 ? req1_relation : req0_relation;
`ifdef COMPARE_SCHED_SIGNED_EN
            r_sgn   <= w_grant1 ? req1_signed : req0_signed;
`endif
         end
         if (r_state == S_EXEC) begin
            if (r_owner) begin
               r_res1 <= DW'(w_bit);
               r_err1 <= ~w_rel_ok;
            end else begin
               r_res0 <= DW'(w_bit);
               r_err0 <= ~w_rel_ok;
            end
         end
      end
   end

   assign resp0_result = r_res0;
   assign resp0_err    = r_err0;
   assign resp1_result = r_res1;
   assign resp1_err    = r_err1;

endmodule

// File: tb/tb_compare_sched.sv
// Bench for compare_sched: directed and random transactions against a reference model.
// Build with COMPARE_SCHED_SIGNED_EN to also exercise signed comparisons.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ALU_SMALLER
`define ALU_SMALLER  0
`define ALU_EQUAL    1
`define ALU_LARGER   2
`define ALU_NSMALLER 3
`define ALU_NEQUAL   4
`define ALU_NLARGER  5
`endif

module tb_compare_sched;

   localparam int unsigned DW = `DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_err;
   logic          req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_err;
   logic [DW-1:0] req0_op0, req0_op1, req0_relation, resp0_result;
   logic [DW-1:0] req1_op0, req1_op1, req1_relation, resp1_result;
   logic [DW-1:0] cmp_op0, cmp_op1, cmp_relation, cmp_result;
`ifdef COMPARE_SCHED_SIGNED_EN
   logic          req0_signed, req1_signed;
`endif

   int            n_pass  = 0;
   int            n_total = 0;
   logic          m_prio;
   logic [DW-1:0] m_res [2];
   logic          m_err [2];
   logic          sgn_in [2];
   logic          cu_bit;

   always #5 clk = ~clk;

   compare_sched #(.RR_INIT(0), .IDLE_ZERO(1)) dut (
      .clk(clk), .rst(rst),
`ifdef COMPARE_SCHED_SIGNED_EN
      .req0_signed(req0_signed), .req1_signed(req1_signed),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op0(req0_op0), .req0_op1(req0_op1), .req0_relation(req0_relation),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_result(resp0_result), .resp0_err(resp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op0(req1_op0), .req1_op1(req1_op1), .req1_relation(req1_relation),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_result(resp1_result), .resp1_err(resp1_err),
      .cmp_op0(cmp_op0), .cmp_op1(cmp_op1), .cmp_relation(cmp_relation),
      .cmp_result(cmp_result)
   );

   // Stand-in for the unsigned compare unit; junk in upper bits and for bad codes.
   always_comb begin
      cu_bit = 1'b1;
      case (cmp_relation)
         DW'(`ALU_SMALLER):  cu_bit = cmp_op0 <  cmp_op1;
         DW'(`ALU_EQUAL):    cu_bit = cmp_op0 == cmp_op1;
         DW'(`ALU_LARGER):   cu_bit = cmp_op0 >  cmp_op1;
         DW'(`ALU_NSMALLER): cu_bit = cmp_op0 >= cmp_op1;
         DW'(`ALU_NEQUAL):   cu_bit = cmp_op0 != cmp_op1;
         DW'(`ALU_NLARGER):  cu_bit = cmp_op0 <= cmp_op1;
         default:            cu_bit = 1'b1;
      endcase
      cmp_result = {{(DW-1){1'b1}}, cu_bit};
   end

   function automatic logic ref_err(input logic [DW-1:0] rel);
      return !(rel inside {DW'(`ALU_SMALLER), DW'(`ALU_EQUAL), DW'(`ALU_LARGER),
                           DW'(`ALU_NSMALLER), DW'(`ALU_NEQUAL), DW'(`ALU_NLARGER)});
   endfunction

   function automatic logic ref_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [DW-1:0] rel, input logic sgn);
      int ia, ib;
      ia = sgn ? int'($signed(a)) : int'(a);
      ib = sgn ? int'($signed(b)) : int'(b);
      case (rel)
         DW'(`ALU_SMALLER):  return ia <  ib;
         DW'(`ALU_EQUAL):    return ia == ib;
         DW'(`ALU_LARGER):   return ia >  ib;
         DW'(`ALU_NSMALLER): return ia >= ib;
         DW'(`ALU_NEQUAL):   return ia != ib;
         DW'(`ALU_NLARGER):  return ia <= ib;
         default:            return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] rel, input logic s);
      sgn_in[idx] = s;
      if (idx == 0) begin
         req0_op0 = a; req0_op1 = b; req0_relation = rel;
      end else begin
         req1_op0 = a; req1_op1 = b; req1_relation = rel;
      end
`ifdef COMPARE_SCHED_SIGNED_EN
      req0_signed = sgn_in[0];
      req1_signed = sgn_in[1];
`endif
   endtask

   task automatic load_rand(input int idx);
      logic [DW-1:0] rel;
      logic          s;
      int            k;
      k   = int'($urandom_range(0, 7));
      rel = (k < 6) ? DW'(k) : DW'($urandom_range(6, 255));
      s   = 1'b0;
`ifdef COMPARE_SCHED_SIGNED_EN
      s   = 1'($urandom_range(0, 1));
`endif
      load(idx, DW'($urandom), DW'($urandom), rel, s);
   endtask

   // One complete transaction: arbitration, execute, response with bp stall cycles.
   task automatic txn(input logic v0, input logic v1, input int bp);
      int            g;
      logic [DW-1:0] ea, eb, erel, mask;
      logic          es;
      req0_valid = v0;
      req1_valid = v1;
      #1;
      g = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);
      chk("idle_cmp_op0", cmp_op0, 0);
      chk("idle_cmp_rel", cmp_relation, 0);
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      ea   = (g == 1) ? req1_op0 : req0_op0;
      eb   = (g == 1) ? req1_op1 : req0_op1;
      erel = (g == 1) ? req1_relation : req0_relation;
      es   = sgn_in[g];
      mask = es ? (DW'(1) << (DW - 1)) : '0;
      m_res[g] = DW'(ref_cmp(ea, eb, erel, es));
      m_err[g] = ref_err(erel);
      m_prio   = (g == 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      load_rand(0);
      load_rand(1);
      #1;
      chk("exec_resp0_valid", resp0_valid, 0);
      chk("exec_resp1_valid", resp1_valid, 0);
      chk("exec_cmp_op0", cmp_op0, ea ^ mask);
      chk("exec_cmp_op1", cmp_op1, eb ^ mask);
      chk("exec_cmp_rel", cmp_relation, erel);
      tick();
      req0_valid  = 1'b1;
      req1_valid  = 1'b1;
      resp0_ready = (g == 1);
      resp1_ready = (g == 0);
      for (int i = 0; i <= bp; i++) begin
         if (i == bp) begin
            resp0_ready = 1'b1;
            resp1_ready = 1'b1;
         end
         #1;
         chk("resp0_valid", resp0_valid, g == 0);
         chk("resp1_valid", resp1_valid, g == 1);
         chk("resp_result", (g == 1) ? resp1_result : resp0_result, m_res[g]);
         chk("resp_err", (g == 1) ? resp1_err : resp0_err, m_err[g]);
         chk("resp_no_accept", {req1_ready, req0_ready}, 0);
         chk("resp_cmp_op0", cmp_op0, 0);
         tick();
      end
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      #1;
      chk("post_resp_valid", {resp1_valid, resp0_valid}, 0);
      chk("hold_resp0_result", resp0_result, m_res[0]);
      chk("hold_resp1_result", resp1_result, m_res[1]);
      chk("hold_resp0_err", resp0_err, m_err[0]);
      chk("hold_resp1_err", resp1_err, m_err[1]);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      tick();
      tick();
      rst      = 1'b0;
      m_prio   = 1'b0;
      m_res[0] = '0; m_res[1] = '0;
      m_err[0] = 1'b0; m_err[1] = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
      chk({tag, "_valid"}, {resp1_valid, resp0_valid}, 0);
      chk({tag, "_res0"}, resp0_result, 0);
      chk({tag, "_res1"}, resp1_result, 0);
      chk({tag, "_err"}, {resp1_err, resp0_err}, 0);
      chk({tag, "_cmp"}, {cmp_op0, cmp_op1, cmp_relation}, 0);
   endtask

   initial begin
      load(0, '0, '0, '0, 1'b0);
      load(1, '0, '0, '0, 1'b0);
      do_reset();
      #1;
      chk_reset_state("reset");

      // Single request from requester 0: 5 < 9.
      load(0, DW'(8'h05), DW'(8'h09), DW'(`ALU_SMALLER), 1'b0);
      txn(1'b1, 1'b0, 0);
      chk("single_result", resp0_result, DW'(8'h01));

      // Both requesters valid back to back after a fresh reset: grants 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         load_rand(0);
         load(1, DW'(8'h3C), DW'(8'h3C), DW'(`ALU_EQUAL), 1'b0);
         txn(1'b1, 1'b1, 0);
      end
      chk("equal_result", resp1_result, DW'(8'h01));

      // Undefined relation code on requester 1.
      load(1, DW'($urandom), DW'($urandom), DW'(8'hFF), 1'b0);
      txn(1'b0, 1'b1, 0);
      chk("bad_rel_result", resp1_result, 0);
      chk("bad_rel_err", resp1_err, 1);

      // Response backpressure for five cycles.
      load_rand(0);
      txn(1'b1, 1'b0, 5);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         int k;
         k = int'($urandom_range(1, 3));
         load_rand(0);
         load_rand(1);
         txn(k[0], k[1], int'($urandom_range(0, 2)));
      end

`ifdef COMPARE_SCHED_SIGNED_EN
      // -2 < 1 only when compared as signed.
      load(0, DW'(8'hFE), DW'(8'h01), DW'(`ALU_SMALLER), 1'b1);
      txn(1'b1, 1'b0, 0);
      chk("signed_result", resp0_result, DW'(8'h01));
      load(0, DW'(8'hFE), DW'(8'h01), DW'(`ALU_SMALLER), 1'b0);
      txn(1'b1, 1'b0, 0);
      chk("unsigned_result", resp0_result, DW'(8'h00));
`endif

      // Reset while the accepted request is in EXEC.
      load(0, DW'(8'h01), DW'(8'h02), DW'(`ALU_SMALLER), 1'b0);
      req0_valid = 1'b1;
      #1;
      chk("rst_accept", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      rst        = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk_reset_state("rst_exec");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_resp", {resp1_valid, resp0_valid}, 0);
      end
      m_prio   = 1'b0;
      m_res[0] = '0; m_res[1] = '0;
      m_err[0] = 1'b0; m_err[1] = 1'b0;
      load_rand(0);
      load_rand(1);
      txn(1'b1, 1'b1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
